// File: rtl/upd78xx_opfetch_if.sv
// Bus and sequencer signals of the uPD78xx opcode fetch unit.
// The master modport is the fetch unit; the slave modport is memory plus sequencer.
interface upd78xx_opfetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] A;
  logic [7:0]        DB_I;
  logic              M1;
  logic              OP_VALID;
  logic              OP_READY;
  logic [10:0]       OP_CODE;
  logic [ADDR_W-1:0] OP_PC;
  logic              LOAD_PC;
  logic [ADDR_W-1:0] NEW_PC;
  logic              HOLD;
  logic              HOLD_ACK;

  modport master (
    output A, M1, OP_VALID, OP_CODE, OP_PC, HOLD_ACK,
    input  DB_I, OP_READY, LOAD_PC, NEW_PC, HOLD
  );

  modport slave (
    input  A, M1, OP_VALID, OP_CODE, OP_PC, HOLD_ACK,
    output DB_I, OP_READY, LOAD_PC, NEW_PC, HOLD
  );
endinterface

// File: rtl/upd78xx_opfetch.sv
// Opcode fetch/prefetch unit: phased bus reads into a byte queue, with prefix folding
// into 11-bit opcodes handed to the sequencer over a valid/ready handshake.
module upd78xx_opfetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter int                T_STATES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               CLK,
  input logic               RESET,
  input logic               CP1_POSEDGE,
  input logic               CP2_POSEDGE,
  input logic               CP2_NEGEDGE,
  upd78xx_opfetch_if.master bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OCC_W  = CNT_W + 1;
  localparam int SECOND = (DEPTH > 1) ? 1 : 0;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_TPRE = 4'(T_STATES - 1);
  localparam logic [3:0] S_TN   = 4'(T_STATES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ent_t;

  function automatic logic [2:0] pfx_idx(input logic [7:0] b);
    case (b)
      8'h48:   return 3'd1;
      8'h4C:   return 3'd2;
      8'h4D:   return 3'd3;
      8'h60:   return 3'd4;
      8'h64:   return 3'd5;
      8'h70:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  logic [3:0]        st_q, st_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              m1_q, m1_d;
  logic              drop_q, drop_d;
  logic [7:0]        data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_valid_q, op_valid_d;
  logic [10:0]       op_code_q, op_code_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic              hold_ack_q, hold_ack_d;
  ent_t              q_q [DEPTH];
  ent_t              q_d [DEPTH];
  ent_t              ext [DEPTH+2];

  logic              cyc_end, push, start, xfer;
  logic [OCC_W-1:0]  occupancy;
  logic [2:0]        head_idx;
  int                pop_n, cnt_after_pop;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cyc_end   = (st_q == S_TN) && CP2_NEGEDGE;
    push      = cyc_end && !drop_q && !bus.LOAD_PC;
    occupancy = {1'b0, cnt_q} + OCC_W'(push);
    start     = CP2_NEGEDGE && (st_q == S_IDLE || st_q == S_TN) &&
                !bus.HOLD && !bus.LOAD_PC && (occupancy < DEPTH_C);

    st_d = st_q;
    if (start)                            st_d = S_T1;
    else if (cyc_end)                     st_d = S_IDLE;
    else if (st_q != S_IDLE && CP2_NEGEDGE) st_d = st_q + 4'd1;

    fpc_d = fpc_q;
    if (bus.LOAD_PC)                                      fpc_d = bus.NEW_PC;
    else if (st_q == S_TN && CP2_POSEDGE && !drop_q)      fpc_d = fpc_q + ADDR_W'(1);

    a_d  = a_q;
    m1_d = m1_q;
    if (st_q == S_T1 && CP1_POSEDGE) begin
      a_d  = fpc_q;
      m1_d = 1'b1;
    end else if (st_q == S_TN && CP1_POSEDGE) begin
      m1_d = 1'b0;
    end

    // A cycle aborted by LOAD_PC still runs to completion; this flag discards its byte.
    drop_d = drop_q;
    if (start)            drop_d = 1'b0;
    else if (bus.LOAD_PC) drop_d = 1'b1;

    data_d = (st_q == S_TPRE && CP2_NEGEDGE) ? bus.DB_I : data_q;

    xfer          = op_valid_q && bus.OP_READY && !bus.LOAD_PC;
    pop_n         = !xfer ? 0 : (op_code_q[10:8] != 3'd0) ? 2 : 1;
    cnt_after_pop = int'(cnt_q) - pop_n;

    ext = '{default: '0};
    for (int i = 0; i < DEPTH; i++) ext[i] = q_q[i];
    q_d = q_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (i + pop_n < int'(cnt_q)) begin
        case (pop_n)
          1:       q_d[i] = ext[i+1];
          2:       q_d[i] = ext[i+2];
          default: q_d[i] = ext[i];
        endcase
      end else if (push && i == cnt_after_pop) begin
        q_d[i] = '{addr: a_q, data: data_q};
      end
    end
    cnt_d = bus.LOAD_PC ? '0 : CNT_W'(cnt_after_pop + int'(push));

    // Output registers are loaded from the post-update queue, so a push or pop shows next CLK.
    head_idx   = pfx_idx(q_d[0].data);
    op_valid_d = 1'b0;
    op_code_d  = op_code_q;
    op_pc_d    = op_pc_q;
    if (cnt_d != '0) begin
      if (head_idx == 3'd0) begin
        op_valid_d = 1'b1;
        op_code_d  = {3'd0, q_d[0].data};
        op_pc_d    = q_d[0].addr;
      end else if (int'(cnt_d) >= 2) begin
        op_valid_d = 1'b1;
        op_code_d  = {head_idx, q_d[SECOND].data};
        op_pc_d    = q_d[0].addr;
      end
    end

    hold_ack_d = (st_d == S_IDLE) && bus.HOLD;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q       <= S_IDLE;
      fpc_q      <= RESET_PC;
      a_q        <= RESET_PC;
      m1_q       <= 1'b0;
      drop_q     <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      op_pc_q    <= '0;
      hold_ack_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      fpc_q      <= fpc_d;
      a_q        <= a_d;
      m1_q       <= m1_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_pc_q    <= op_pc_d;
      hold_ack_q <= hold_ack_d;
    end
  end

  // NOTE: queue storage is not reset; cnt_q alone decides which entries are meaningful.
  always_ff @(posedge CLK) q_q <= q_d;

  assign bus.A        = a_q;
  assign bus.M1       = m1_q;
  assign bus.OP_VALID = op_valid_q;
  assign bus.OP_CODE  = op_code_q;
  assign bus.OP_PC    = op_pc_q;
  assign bus.HOLD_ACK = hold_ack_q;

endmodule

// File: tb/tb_upd78xx_opfetch.sv
// Directed bench for upd78xx_opfetch: a sequential-program model predicts every opcode
// and every fetch address; literal expectations pin the model on the key scenarios.
module tb_upd78xx_opfetch;
  localparam int T_ST = 4;
  localparam int PER  = 4;   // CLKs per T-state in the phase generator

  logic clk = 1'b0, rst = 1'b1, cp1 = 1'b0, cp2p = 1'b0, cp2n = 1'b0;
  int   ph = 0;
  always #5 clk = ~clk;

  upd78xx_opfetch_if #(.ADDR_W(16)) bus ();

  upd78xx_opfetch #(.ADDR_W(16), .DEPTH(2), .T_STATES(T_ST), .RESET_PC(16'h0000)) dut (
    .CLK(clk), .RESET(rst), .CP1_POSEDGE(cp1), .CP2_POSEDGE(cp2p), .CP2_NEGEDGE(cp2n),
    .bus(bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.DB_I = mem[bus.A];

  int n_total = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: program bytes are consumed in address order; prefixes fold with the next byte.
  function automatic logic [2:0] prefix_of(input logic [7:0] b);
    case (b)
      8'h48: return 3'd1;  8'h4C: return 3'd2;  8'h4D: return 3'd3;
      8'h60: return 3'd4;  8'h64: return 3'd5;  8'h70: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] expect_op(input logic [15:0] pc, output int len);
    logic [2:0]  idx;
    logic [15:0] pc2;
    idx = prefix_of(mem[pc]);
    pc2 = pc + 16'd1;
    len = (idx == 3'd0) ? 1 : 2;
    if (idx == 3'd0) return {5'd0, 3'd0, mem[pc], pc};
    return {5'd0, idx, mem[pc2], pc};
  endfunction

  logic [15:0] exp_pc = 16'h0000, exp_fetch = 16'h0000;
  logic [31:0] tr_log [$];
  logic [15:0] a_log [$];
  int          m1_rises = 0, m1_len = 0;
  logic        m1_prev = 1'b0, m1_abort = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    int len;
    if (bus.OP_VALID === 1'b1) begin
      e = expect_op(exp_pc, len);
      check("op_out", {5'd0, bus.OP_CODE, bus.OP_PC}, e);
      if (bus.OP_READY && !bus.LOAD_PC && !rst) begin
        tr_log.push_back({5'd0, bus.OP_CODE, bus.OP_PC});
        exp_pc = exp_pc + 16'(len);
      end
    end
    if (bus.M1 === 1'b1 && !m1_prev) begin
      check("fetch_addr", {16'd0, bus.A}, {16'd0, exp_fetch});
      a_log.push_back(bus.A);
      exp_fetch = exp_fetch + 16'd1;
      m1_rises++;
      m1_len   = 0;
      m1_abort = 1'b0;
    end
    if (bus.M1 === 1'b1) m1_len++;
    if (bus.M1 === 1'b0 && m1_prev && !m1_abort) check("m1_width", m1_len, (T_ST - 1) * PER);
    if (bus.HOLD_ACK === 1'b1) check("hold_ack_bus_off", {31'd0, bus.M1}, 32'd0);
    if (rst) begin
      exp_pc    = 16'h0000;
      exp_fetch = 16'h0000;
      if (bus.M1 === 1'b1) m1_abort = 1'b1;
    end else if (bus.LOAD_PC) begin
      exp_pc    = bus.NEW_PC;
      exp_fetch = bus.NEW_PC;
    end
    m1_prev = (bus.M1 === 1'b1);
  end

  // Phase enables: CP1 / CP2 rise / -- / CP2 fall, one T-state every PER CLKs.
  initial begin
    forever begin
      @(posedge clk); #1;
      cp1  = (ph == 0);
      cp2p = (ph == 1);
      cp2n = (ph == 3);
      ph   = (ph + 1) % PER;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rise(input string tag);
    int r0;
    bit ok;
    r0 = m1_rises;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick(1);
      if (m1_rises != r0) ok = 1'b1;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_tr(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      tick(1);
      if (tr_log.size() >= n) ok = 1'b1;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_addr(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      tick(1);
      if (a_log.size() >= n) ok = 1'b1;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  function automatic logic [31:0] tr_at(input int i);
    return (i < tr_log.size()) ? tr_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] a_at(input int i);
    return (i < a_log.size()) ? {16'd0, a_log[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic load_pc_pulse(input logic [15:0] pc);
    bus.LOAD_PC = 1'b1;
    bus.NEW_PC  = pc;
    tick(1);
    bus.LOAD_PC = 1'b0;
  endtask

  initial begin
    int ti, ai, r0;
    bit ok;
    logic [15:0] a_before;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h00; mem[1] = 8'h12; mem[2] = 8'h48; mem[3] = 8'h2A;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h99;
    bus.OP_READY = 1'b1; bus.LOAD_PC = 1'b0; bus.NEW_PC = '0; bus.HOLD = 1'b0;

    // Reset values
    tick(6);
    check("rst_A",        {16'd0, bus.A}, 32'd0);
    check("rst_M1",       {31'd0, bus.M1}, 32'd0);
    check("rst_OP_VALID", {31'd0, bus.OP_VALID}, 32'd0);
    check("rst_OP_CODE",  {21'd0, bus.OP_CODE}, 32'd0);
    check("rst_OP_PC",    {16'd0, bus.OP_PC}, 32'd0);
    check("rst_HOLD_ACK", {31'd0, bus.HOLD_ACK}, 32'd0);

    // Plain + prefixed opcodes from address 0
    rst = 1'b0;
    ti = tr_log.size();
    wait_tr(ti + 3, "seq_timeout");
    check("seq_op0", tr_at(ti),     32'h0000_0000);
    check("seq_op1", tr_at(ti + 1), 32'h0012_0001);
    check("seq_op2", tr_at(ti + 2), 32'h012A_0002);

    // Sequencer stalled: two bus cycles fill the queue, then the bus goes quiet
    rst = 1'b1; bus.OP_READY = 1'b0;
    tick(2);
    rst = 1'b0;
    r0 = m1_rises;
    tick(300);
    check("full_cycles",  m1_rises - r0, 32'd2);
    check("full_m1_low",  {31'd0, bus.M1}, 32'd0);
    check("full_valid",   {31'd0, bus.OP_VALID}, 32'd1);
    check("full_head",    {5'd0, bus.OP_CODE, bus.OP_PC}, 32'h0000_0000);
    bus.OP_READY = 1'b1;
    wait_rise("resume_timeout");

    // LOAD_PC in T2 of the fetch at 0x0005
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      wait_rise("find5_timeout");
      if (a_log.size() > 0 && a_log[$] == 16'h0005) ok = 1'b1;
    end
    check("find_fetch5", {31'd0, ok}, 32'd1);
    tick(3);
    load_pc_pulse(16'h8000);
    ti = tr_log.size(); ai = a_log.size();
    wait_tr(ti + 1, "load_tr_timeout");
    wait_addr(ai + 1, "load_a_timeout");
    check("load_first_A",  a_at(ai), 32'h0000_8000);
    check("load_first_op", tr_at(ti), 32'h0299_8000);

    // Wrap of the fetch pointer across 0xFFFF
    mem[16'hFFFF] = 8'h70; mem[16'h0000] = 8'h33;
    wait_rise("wrap_sync_timeout");
    tick(3);
    load_pc_pulse(16'hFFFF);
    ti = tr_log.size(); ai = a_log.size();
    wait_addr(ai + 3, "wrap_a_timeout");
    wait_tr(ti + 1, "wrap_tr_timeout");
    check("wrap_A0", a_at(ai),     32'h0000_FFFF);
    check("wrap_A1", a_at(ai + 1), 32'h0000_0000);
    check("wrap_A2", a_at(ai + 2), 32'h0000_0001);
    check("wrap_op", tr_at(ti),    32'h0633_FFFF);

    // HOLD raised in T2: the cycle completes, then the unit parks off the bus
    wait_rise("hold_sync_timeout");
    a_before = a_log[$];
    tick(3);
    bus.HOLD = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (bus.HOLD_ACK) ok = 1'b1;
    end
    check("hold_ack_rise", {31'd0, ok}, 32'd1);
    check("hold_m1_low",   {31'd0, bus.M1}, 32'd0);
    r0 = m1_rises;
    tick(60);
    check("hold_no_fetch", m1_rises - r0, 32'd0);
    check("hold_ack_kept", {31'd0, bus.HOLD_ACK}, 32'd1);
    bus.HOLD = 1'b0;
    tick(1);
    check("hold_ack_drop", {31'd0, bus.HOLD_ACK}, 32'd0);
    ai = a_log.size();
    wait_addr(ai + 1, "hold_resume_timeout");
    check("hold_next_A", a_at(ai), {16'd0, 16'(a_before + 16'd1)});

    // RESET during T3 aborts the cycle and restarts at RESET_PC
    wait_rise("rst_sync_timeout");
    tick(7);
    rst = 1'b1;
    tick(1);
    check("midrst_A",     {16'd0, bus.A}, 32'd0);
    check("midrst_M1",    {31'd0, bus.M1}, 32'd0);
    check("midrst_valid", {31'd0, bus.OP_VALID}, 32'd0);
    rst = 1'b0;
    ti = tr_log.size(); ai = a_log.size();
    wait_addr(ai + 1, "midrst_a_timeout");
    wait_tr(ti + 1, "midrst_tr_timeout");
    check("midrst_first_A",  a_at(ai),  32'h0000_0000);
    check("midrst_first_op", tr_at(ti), 32'h0033_0000);

    tick(20);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
